// File: rtl/id_stage_s.sv
// id_stage_s: RV32I instruction-decode stage.
// Holds the 32x32 register file with write-first bypass, decodes the fetched
// instruction into control bits and immediate, detects load-use hazards and
// loads the ID/EX pipeline register one cycle after the fetch presents a word.
module id_stage_s (
  input  logic        clk,
  input  logic        reset,
  input  logic        is_flush,
  input  logic        if_valid,
  input  logic [31:0] if_pc,
  input  logic [31:0] if_instr,
  input  logic        wb_we,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  input  logic        ex_mem_read,
  input  logic [4:0]  ex_rd,
  output logic        is_stall,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] rs1_data,
  output logic [31:0] rs2_data,
  output logic [31:0] imm,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic [2:0]  funct3,
  output logic [6:0]  funct7,
  output logic [7:0]  ctrl
);

  // RV32I major opcodes
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I_ALU  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  // ctrl bit positions
  localparam int C_REG_WRITE = 0;
  localparam int C_MEM_READ  = 1;
  localparam int C_MEM_WRITE = 2;
  localparam int C_ALU_IMM   = 3;
  localparam int C_BRANCH    = 4;
  localparam int C_JUMP      = 5;
  localparam int C_PC_OPND   = 6;
  localparam int C_ILLEGAL   = 7;

  // Instruction fields
  logic [6:0] opcode;
  logic [4:0] rs1_idx, rs2_idx, rd_idx;
  assign opcode  = if_instr[6:0];
  assign rs1_idx = if_instr[19:15];
  assign rs2_idx = if_instr[24:20];
  assign rd_idx  = if_instr[11:7];

  // Register file
  logic [31:0] regs_q [32];
  logic [31:0] regs_d [32];
  logic        wb_write;
  assign wb_write = wb_we && (wb_rd != 5'd0);

  // Register file next state: single write port, x0 never written
  always_comb begin
    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
    regs_d = regs_q;
    if (wb_write) regs_d[wb_rd] = wb_data;
  end

  // Register file storage, cleared by reset
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: the register file must read zero after reset, so this memory is deliberately reset (it becomes flops, not RAM).
    if (reset) regs_q <= '{default: '0};
    else       regs_q <= regs_d;
  end

  // Read ports with write-first bypass; x0 is hard-wired to zero
  logic [31:0] rs1_val, rs2_val;
  always_comb begin
    rs1_val = regs_q[rs1_idx];
    rs2_val = regs_q[rs2_idx];
    if (wb_write && (wb_rd == rs1_idx)) rs1_val = wb_data;
    if (wb_write && (wb_rd == rs2_idx)) rs2_val = wb_data;
    if (rs1_idx == 5'd0) rs1_val = '0;
    if (rs2_idx == 5'd0) rs2_val = '0;
  end

  // Immediate formats
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  assign imm_i = {{20{if_instr[31]}}, if_instr[31:20]};
  assign imm_s = {{20{if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
  assign imm_b = {{19{if_instr[31]}}, if_instr[31], if_instr[7], if_instr[30:25], if_instr[11:8], 1'b0};
  assign imm_u = {if_instr[31:12], 12'b0};
  assign imm_j = {{11{if_instr[31]}}, if_instr[31], if_instr[19:12], if_instr[20], if_instr[30:21], 1'b0};

  // Opcode decode: control bits, immediate select and source-register usage
  logic [7:0]  ctrl_dec;
  logic [31:0] imm_dec;
  logic        use_rs1, use_rs2;
  always_comb begin
    ctrl_dec = '0;
    imm_dec  = '0;
    use_rs1  = 1'b1;
    use_rs2  = 1'b0;
    case (opcode)
      OP_R: begin
        ctrl_dec[C_REG_WRITE] = 1'b1;
        use_rs2 = 1'b1;
      end
      OP_I_ALU: begin
        ctrl_dec[C_REG_WRITE] = 1'b1;
        ctrl_dec[C_ALU_IMM]   = 1'b1;
        imm_dec = imm_i;
      end
      OP_LOAD: begin
        ctrl_dec[C_REG_WRITE] = 1'b1;
        ctrl_dec[C_MEM_READ]  = 1'b1;
        ctrl_dec[C_ALU_IMM]   = 1'b1;
        imm_dec = imm_i;
      end
      OP_STORE: begin
        ctrl_dec[C_MEM_WRITE] = 1'b1;
        ctrl_dec[C_ALU_IMM]   = 1'b1;
        imm_dec = imm_s;
        use_rs2 = 1'b1;
      end
      OP_BRANCH: begin
        ctrl_dec[C_BRANCH] = 1'b1;
        imm_dec = imm_b;
        use_rs2 = 1'b1;
      end
      OP_JAL: begin
        ctrl_dec[C_REG_WRITE] = 1'b1;
        ctrl_dec[C_JUMP]      = 1'b1;
        ctrl_dec[C_PC_OPND]   = 1'b1;
        imm_dec = imm_j;
        use_rs1 = 1'b0;
      end
      OP_JALR: begin
        ctrl_dec[C_REG_WRITE] = 1'b1;
        ctrl_dec[C_JUMP]      = 1'b1;
        ctrl_dec[C_ALU_IMM]   = 1'b1;
        imm_dec = imm_i;
      end
      OP_LUI: begin
        ctrl_dec[C_REG_WRITE] = 1'b1;
        ctrl_dec[C_ALU_IMM]   = 1'b1;
        imm_dec = imm_u;
        use_rs1 = 1'b0;
      end
      OP_AUIPC: begin
        ctrl_dec[C_REG_WRITE] = 1'b1;
        ctrl_dec[C_ALU_IMM]   = 1'b1;
        ctrl_dec[C_PC_OPND]   = 1'b1;
        imm_dec = imm_u;
        use_rs1 = 1'b0;
      end
      default: ctrl_dec[C_ILLEGAL] = 1'b1;
    endcase
  end

  // Load-use hazard: the load in EX targets a register this instruction reads
  logic hazard;
  always_comb begin
    hazard = ex_mem_read && (ex_rd != 5'd0) &&
             ((use_rs1 && (ex_rd == rs1_idx)) || (use_rs2 && (ex_rd == rs2_idx)));
    is_stall = if_valid && !is_flush && hazard;
  end

  // Pipeline register state
  logic        id_valid_q, id_valid_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] rs1_data_q, rs1_data_d;
  logic [31:0] rs2_data_q, rs2_data_d;
  logic [31:0] imm_q, imm_d;
  logic [4:0]  rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [6:0]  funct7_q, funct7_d;
  logic [7:0]  ctrl_q, ctrl_d;

  // Next ID/EX contents: bubble (valid=0, ctrl=0) on flush, stall or no fetch
  always_comb begin
    id_valid_d = if_valid && !is_flush && !is_stall;
    ctrl_d     = id_valid_d ? ctrl_dec : 8'h00;
    id_pc_d    = if_pc;
    rs1_data_d = rs1_val;
    rs2_data_d = rs2_val;
    imm_d      = imm_dec;
    rs1_d      = rs1_idx;
    rs2_d      = rs2_idx;
    rd_d       = rd_idx;
    funct3_d   = if_instr[14:12];
    funct7_d   = if_instr[31:25];
  end

  // ID/EX pipeline register
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      id_valid_q <= 1'b0;
      id_pc_q    <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_q      <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
      funct3_q   <= '0;
      funct7_q   <= '0;
      ctrl_q     <= '0;
    end else begin
      id_valid_q <= id_valid_d;
      id_pc_q    <= id_pc_d;
      rs1_data_q <= rs1_data_d;
      rs2_data_q <= rs2_data_d;
      imm_q      <= imm_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      rd_q       <= rd_d;
      funct3_q   <= funct3_d;
      funct7_q   <= funct7_d;
      ctrl_q     <= ctrl_d;
    end
  end

  assign id_valid = id_valid_q;
  assign id_pc    = id_pc_q;
  assign rs1_data = rs1_data_q;
  assign rs2_data = rs2_data_q;
  assign imm      = imm_q;
  assign rs1      = rs1_q;
  assign rs2      = rs2_q;
  assign rd       = rd_q;
  assign funct3   = funct3_q;
  assign funct7   = funct7_q;
  assign ctrl     = ctrl_q;

endmodule

// File: tb/tb_id_stage_s.sv
// tb_id_stage_s: scoreboard bench for id_stage_s. Each driven instruction
// pushes its expected ID/EX contents; they are popped and compared after the edge.
module tb_id_stage_s;

  logic        clk = 1'b0;
  logic        reset;
  logic        is_flush, if_valid;
  logic [31:0] if_pc, if_instr;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        ex_mem_read;
  logic [4:0]  ex_rd;
  logic        is_stall, id_valid;
  logic [31:0] id_pc, rs1_data, rs2_data, imm;
  logic [4:0]  rs1, rs2, rd;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [7:0]  ctrl;

  id_stage_s dut (
    .clk(clk), .reset(reset), .is_flush(is_flush), .if_valid(if_valid),
    .if_pc(if_pc), .if_instr(if_instr), .wb_we(wb_we), .wb_rd(wb_rd),
    .wb_data(wb_data), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
    .is_stall(is_stall), .id_valid(id_valid), .id_pc(id_pc),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm), .rs1(rs1),
    .rs2(rs2), .rd(rd), .funct3(funct3), .funct7(funct7), .ctrl(ctrl)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        full;   // fields beyond valid/ctrl are meaningful
    logic        valid;
    logic [7:0]  ctrl;
    logic [31:0] pc, rs1d, rs2d, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  f3;
    logic [6:0]  f7;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] m_regs [32];
  logic [31:0] pc_cnt = 32'h0000_1000;
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference decoder written from the opcode table
  function automatic void ref_dec(input logic [31:0] i, output logic [7:0] c,
                                  output logic [31:0] im, output logic u1, output logic u2);
    u1 = 1'b1; u2 = 1'b0; im = 32'h0;
    case (i[6:0])
      7'b0110011: begin c = 8'h01; u2 = 1'b1; end
      7'b0010011: begin c = 8'h09; im = {{20{i[31]}}, i[31:20]}; end
      7'b0000011: begin c = 8'h0B; im = {{20{i[31]}}, i[31:20]}; end
      7'b0100011: begin c = 8'h0C; im = {{20{i[31]}}, i[31:25], i[11:7]}; u2 = 1'b1; end
      7'b1100011: begin c = 8'h10; im = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0}; u2 = 1'b1; end
      7'b1101111: begin c = 8'h61; im = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0}; u1 = 1'b0; end
      7'b1100111: begin c = 8'h29; im = {{20{i[31]}}, i[31:20]}; end
      7'b0110111: begin c = 8'h09; im = {i[31:12], 12'h000}; u1 = 1'b0; end
      7'b0010111: begin c = 8'h49; im = {i[31:12], 12'h000}; u1 = 1'b0; end
      default:    c = 8'h80;
    endcase
  endfunction

  function automatic logic [31:0] ref_read(input logic [4:0] idx, input logic we,
                                           input logic [4:0] wrd, input logic [31:0] wdat);
    if (idx == 5'd0)               return 32'h0;
    if (we && wrd == idx)          return wdat;
    return m_regs[idx];
  endfunction

  // Drive one cycle of inputs, check is_stall, push expectation, pop after edge
  task automatic step(input logic v, input logic [31:0] instr, input logic fl,
                      input logic exmr, input logic [4:0] exrd,
                      input logic we, input logic [4:0] wrd, input logic [31:0] wdat);
    logic [7:0]  c;
    logic [31:0] im;
    logic        u1, u2, stall;
    exp_t        e, got;
    if_valid = v; if_instr = instr; is_flush = fl; if_pc = pc_cnt;
    ex_mem_read = exmr; ex_rd = exrd; wb_we = we; wb_rd = wrd; wb_data = wdat;
    pc_cnt = pc_cnt + 32'd4;
    #1;
    ref_dec(instr, c, im, u1, u2);
    stall = v && !fl && exmr && exrd != 5'd0 &&
            ((u1 && exrd == instr[19:15]) || (u2 && exrd == instr[24:20]));
    check("is_stall", {31'h0, is_stall}, {31'h0, stall});
    e.full  = v && !fl && !stall;
    e.valid = e.full;
    e.ctrl  = e.full ? c : 8'h00;
    e.pc    = if_pc;
    e.rs1d  = ref_read(instr[19:15], we, wrd, wdat);
    e.rs2d  = ref_read(instr[24:20], we, wrd, wdat);
    e.imm   = im;
    e.rs1   = instr[19:15];
    e.rs2   = instr[24:20];
    e.rd    = instr[11:7];
    e.f3    = instr[14:12];
    e.f7    = instr[31:25];
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (we && wrd != 5'd0) m_regs[wrd] = wdat;
    got = sb.pop_front();
    check("id_valid", {31'h0, id_valid}, {31'h0, got.valid});
    check("ctrl", {24'h0, ctrl}, {24'h0, got.ctrl});
    if (got.full) begin
      check("id_pc", id_pc, got.pc);
      check("rs1_data", rs1_data, got.rs1d);
      check("rs2_data", rs2_data, got.rs2d);
      check("imm", imm, got.imm);
      check("rs1", {27'h0, rs1}, {27'h0, got.rs1});
      check("rs2", {27'h0, rs2}, {27'h0, got.rs2});
      check("rd", {27'h0, rd}, {27'h0, got.rd});
      check("funct3", {29'h0, funct3}, {29'h0, got.f3});
      check("funct7", {25'h0, funct7}, {25'h0, got.f7});
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, {31'h0, id_valid}, 32'h0);
    check({tag, "_pc"}, id_pc, 32'h0);
    check({tag, "_rs1d"}, rs1_data, 32'h0);
    check({tag, "_rs2d"}, rs2_data, 32'h0);
    check({tag, "_imm"}, imm, 32'h0);
    check({tag, "_idx"}, {17'h0, rs1, rs2, rd}, 32'h0);
    check({tag, "_fn"}, {22'h0, funct3, funct7}, 32'h0);
    check({tag, "_ctrl"}, {24'h0, ctrl}, 32'h0);
  endtask

  localparam logic [31:0] ADDI_X6  = 32'h0012_8313; // addi x6,x5,1
  localparam logic [31:0] ADD_X8   = 32'h0073_8433; // add x8,x7,x7
  localparam logic [31:0] ADD_X9   = 32'h0000_04B3; // add x9,x0,x0
  localparam logic [31:0] BEQ      = 32'hFE41_8CE3; // beq x3,x4,-8
  localparam logic [31:0] LUI_X3   = 32'h1234_51B7; // lui x3,0x12345
  localparam logic [31:0] SW       = 32'h0041_A423; // sw x4,8(x3)
  localparam logic [31:0] JAL      = 32'h0100_00EF; // jal x1,+16
  localparam logic [31:0] LW       = 32'hFFC1_A503; // lw x10,-4(x3)
  localparam logic [31:0] AUIPC    = 32'h0000_1297; // auipc x5,1
  localparam logic [31:0] JALR     = 32'h0000_8067; // jalr x0,0(x1)

  function automatic logic [6:0] pick_op(input int k);
    case (k)
      0: return 7'b0110011;  1: return 7'b0010011;  2: return 7'b0000011;
      3: return 7'b0100011;  4: return 7'b1100011;  5: return 7'b1101111;
      6: return 7'b1100111;  7: return 7'b0110111;  8: return 7'b0010111;
      default: return 7'b1111111;
    endcase
  endfunction

  initial begin
    logic [31:0] r, instr;
    logic [4:0]  exrd;
    for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
    reset = 1'b1; is_flush = 0; if_valid = 0; if_pc = 0; if_instr = 0;
    wb_we = 0; wb_rd = 0; wb_data = 0; ex_mem_read = 0; ex_rd = 0;
    @(posedge clk); @(posedge clk); #1;
    check_all_zero("reset");
    check("reset_stall", {31'h0, is_stall}, 32'h0);
    reset = 1'b0;

    // Write-back then read next cycle
    step(0, 32'h0, 0, 0, 0, 1, 5'd5, 32'hDEADBEEF);
    step(1, ADDI_X6, 0, 0, 0, 0, 0, 0);
    check("addi_rs1d", rs1_data, 32'hDEADBEEF);
    check("addi_ctrl", {24'h0, ctrl}, 32'h09);
    // Same-cycle write-first bypass on both ports
    step(1, ADD_X8, 0, 0, 0, 1, 5'd7, 32'h12345678);
    check("bypass_rs2d", rs2_data, 32'h12345678);
    // Write to x0 is ignored
    step(0, 32'h0, 0, 0, 0, 1, 5'd0, 32'd5);
    step(1, ADD_X9, 0, 0, 0, 0, 0, 0);
    check("x0_read", rs1_data, 32'h0);
    // Load-use stall then issue
    step(0, 32'h0, 0, 0, 0, 1, 5'd3, 32'h0000_0033);
    step(0, 32'h0, 0, 0, 0, 1, 5'd4, 32'h0000_0044);
    step(1, BEQ, 0, 1, 5'd3, 0, 0, 0);
    step(1, BEQ, 0, 0, 5'd3, 0, 0, 0);
    check("beq_imm", imm, 32'hFFFFFFF8);
    check("beq_ctrl", {24'h0, ctrl}, 32'h10);
    // LUI does not read rs1; ex_rd=0 never stalls; rs2 unused by I-type
    step(1, LUI_X3, 0, 1, 5'd3, 0, 0, 0);
    check("lui_imm", imm, 32'h12345000);
    step(1, ADD_X9, 0, 1, 5'd0, 0, 0, 0);
    step(1, ADDI_X6, 0, 1, 5'd1, 0, 0, 0);
    step(1, ADD_X8, 0, 1, 5'd7, 0, 0, 0);      // rs2/rs1 hazard
    // Flush overrides stall; invalid fetch makes a bubble
    step(1, BEQ, 1, 1, 5'd3, 0, 0, 0);
    step(0, BEQ, 0, 1, 5'd3, 0, 0, 0);
    step(0, ADDI_X6, 0, 0, 0, 0, 0, 0);
    step(1, 32'hFFFFFFFF, 0, 0, 0, 0, 0, 0);
    check("illegal_ctrl", {24'h0, ctrl}, 32'h80);
    // Remaining formats
    step(1, SW, 0, 0, 0, 0, 0, 0);
    step(1, JAL, 0, 1, 5'd1, 0, 0, 0);
    step(1, LW, 0, 0, 0, 0, 0, 0);
    step(1, AUIPC, 0, 0, 0, 0, 0, 0);
    step(1, JALR, 0, 1, 5'd1, 0, 0, 0);

    // Randomised mix of opcodes, hazards, flushes and write-backs
    for (int n = 0; n < 60; n++) begin
      r     = $urandom;
      instr = {r[31:7], pick_op($urandom_range(0, 9))};
      exrd  = r[0] ? instr[19:15] : instr[24:20];
      step($urandom_range(0, 7) != 0, instr, $urandom_range(0, 9) == 0,
           $urandom_range(0, 1) == 1, exrd, $urandom_range(0, 1) == 1,
           $urandom_range(0, 1) ? instr[19:15] : 5'($urandom_range(0, 31)), $urandom);
    end

    // Mid-stream asynchronous reset
    step(0, 32'h0, 0, 0, 0, 1, 5'd7, 32'hCAFEF00D);
    step(1, ADD_X8, 0, 0, 0, 0, 0, 0);
    #2 reset = 1'b1;
    #1 check_all_zero("async_rst");
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
    step(1, ADD_X8, 0, 0, 0, 0, 0, 0);
    check("post_rst_rs1d", rs1_data, 32'h0);
    check("sb_empty", sb.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
